// File: rtl/mtm_alu_arb_pkg.sv
// mtm_alu_arb_pkg: shared state encoding, flag positions, opcodes and index helper
package mtm_alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int FLAG_CARRY = 3;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 0;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    // Explicit wrap so non-power-of-2 requester counts rotate correctly
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mtm_alu_rr_picker.sv
// mtm_alu_rr_picker: rotating priority encoder starting the scan at rr_ptr
module mtm_alu_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IW-1:0]    rr_ptr,
    output logic [IW-1:0]    win_idx,
    output logic             any_valid
);

    logic [IW:0] w_idx;

    // Scan offsets from farthest to nearest so the closest valid index to rr_ptr wins
    always_comb begin
        win_idx   = '0;
        any_valid = |req_valid;
        w_idx     = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            w_idx = {1'b0, rr_ptr} + (IW + 1)'(j);
            w_idx = (w_idx >= (IW + 1)'(N_REQ)) ? w_idx - (IW + 1)'(N_REQ) : w_idx;
            if (req_valid[w_idx[IW-1:0]]) win_idx = w_idx[IW-1:0];
        end
    end

endmodule

// File: rtl/mtm_alu_arbiter.sv
// mtm_alu_arbiter: round-robin sharing of one ALU core among N_REQ requesters with a done watchdog
module mtm_alu_arbiter
    import mtm_alu_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = 32,
    parameter int OPW     = 3,
    parameter int TIMEOUT = 255,
    parameter int IW      = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*DW-1:0]  req_A,
    input  logic [N_REQ*DW-1:0]  req_B,
    input  logic [N_REQ*OPW-1:0] req_OP,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [DW-1:0]        rsp_C,
    output logic [3:0]           rsp_flags,
    output logic [2:0]           rsp_crc,
    output logic                 rsp_err,
    output logic                 core_start,
    output logic [DW-1:0]        core_A,
    output logic [DW-1:0]        core_B,
    output logic [OPW-1:0]       core_OP,
    input  logic                 core_done,
    input  logic [DW-1:0]        core_C,
    input  logic [3:0]           core_flags,
    input  logic [2:0]           core_crc,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    localparam int WW = $clog2(TIMEOUT + 1);

    state_t          r_state, w_next;
    logic [IW-1:0]   r_rr_ptr, r_grant, w_win;
    logic            w_any, w_accept, w_timeout;
    logic [WW-1:0]   r_wd;
    logic [DW-1:0]   r_core_A, r_core_B, r_rsp_C;
    logic [OPW-1:0]  r_core_OP;
    logic [3:0]      r_rsp_flags;
    logic [2:0]      r_rsp_crc;
    logic            r_rsp_err;

    mtm_alu_rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .win_idx   (w_win),
        .any_valid (w_any)
    );

    assign w_accept  = (r_state == ST_IDLE) && w_any;
    // The watchdog counts WAIT cycles; the TIMEOUT-th WAIT cycle without done is the error cycle
    assign w_timeout = (r_wd == WW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
    always_comb begin
        w_next = (r_state == ST_IDLE)  ? (w_any ? ST_ISSUE : ST_IDLE) :
                 (r_state == ST_ISSUE) ? ST_WAIT :
                 (r_state == ST_WAIT)  ? ((core_done || w_timeout) ? ST_RESP : ST_WAIT) :
                                         ST_IDLE;
    end

    // Output decode: accept strobe, response pulse, issue strobe and busy
    always_comb begin
        req_ready  = w_accept ? (N_REQ'(1) << w_win) : '0;
        rsp_valid  = (r_state == ST_RESP) ? (N_REQ'(1) << r_grant) : '0;
        core_start = (r_state == ST_ISSUE);
        busy       = (r_state != ST_IDLE);
    end

    // Datapath: operand capture at accept, watchdog, result capture and pointer rotation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_wd        <= '0;
            r_core_A    <= '0;
            r_core_B    <= '0;
            r_core_OP   <= '0;
            r_rsp_C     <= '0;
            r_rsp_flags <= '0;
            r_rsp_crc   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant   <= w_win;
                r_core_A  <= req_A[w_win*DW +: DW];
                r_core_B  <= req_B[w_win*DW +: DW];
                r_core_OP <= req_OP[w_win*OPW +: OPW];
            end
            if (r_state == ST_ISSUE) r_wd <= '0;
            if (r_state == ST_WAIT) begin
                if (core_done) begin
                    r_rsp_C     <= core_C;
                    r_rsp_flags <= core_flags;
                    r_rsp_crc   <= core_crc;
                    r_rsp_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_C     <= '0;
                    r_rsp_flags <= '0;
                    r_rsp_crc   <= '0;
                    r_rsp_err   <= 1'b1;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end
            if (r_state == ST_RESP) r_rr_ptr <= IW'(wrap_inc(int'(r_grant), N_REQ));
        end
    end

    assign core_A    = r_core_A;
    assign core_B    = r_core_B;
    assign core_OP   = r_core_OP;
    assign rsp_C     = r_rsp_C;
    assign rsp_flags = r_rsp_flags;
    assign rsp_crc   = r_rsp_crc;
    assign rsp_err   = r_rsp_err;
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_mtm_alu_arbiter.sv
// tb_mtm_alu_arbiter: directed scenario bench for the round-robin ALU arbiter
module tb_mtm_alu_arbiter;
    import mtm_alu_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, req_ready, rsp_valid;
    logic [N*DW-1:0] req_A, req_B;
    logic [N*3-1:0]  req_OP;
    logic [DW-1:0] rsp_C, core_A, core_B, core_C;
    logic [3:0]    rsp_flags, core_flags;
    logic [2:0]    rsp_crc, core_crc, core_OP;
    logic          rsp_err, core_start, core_done, busy;
    logic [1:0]    grant_id;

    int checks = 0;
    int errors = 0;

    mtm_alu_arbiter #(.N_REQ(N), .DW(DW), .OPW(3), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_OP(req_OP),
        .rsp_valid(rsp_valid), .rsp_C(rsp_C), .rsp_flags(rsp_flags),
        .rsp_crc(rsp_crc), .rsp_err(rsp_err),
        .core_start(core_start), .core_A(core_A), .core_B(core_B), .core_OP(core_OP),
        .core_done(core_done), .core_C(core_C), .core_flags(core_flags), .core_crc(core_crc),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_A[i*DW +: DW] = a;
        req_B[i*DW +: DW] = b;
        req_OP[i*3 +: 3]  = op;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({req_ready, rsp_valid, rsp_err, core_start, busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {req_ready, rsp_valid, rsp_err, core_start, busy});
        end
        checks++;
        if ({rsp_C, rsp_flags, rsp_crc, core_A, core_B, core_OP, grant_id} !== '0) begin
            errors++;
            $display("FAIL reset_data: got rsp_C=%h core_A=%h grant=%0d expected 0", rsp_C, core_A, grant_id);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_op();
        set_req(0, 32'd5, 32'd3, OP_ADD);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++;
        if ({core_start, busy, req_ready} !== 6'b110000) begin
            errors++; $display("FAIL single_issue: got start=%b busy=%b ready=%b expected 1 1 0000", core_start, busy, req_ready);
        end
        checks++;
        if (core_A !== 32'd5 || core_B !== 32'd3 || core_OP !== OP_ADD) begin
            errors++; $display("FAIL single_operands: got A=%0d B=%0d OP=%b expected 5 3 100", core_A, core_B, core_OP);
        end
        step();
        checks++;
        if (core_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b expected 0", core_start); end
        step();
        core_done = 1'b1; core_C = 32'd8; core_flags = 4'b0000; core_crc = 3'b011;
        step();
        core_done = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_C !== 32'd8 || rsp_err !== 1'b0 || rsp_crc !== 3'b011) begin
            errors++; $display("FAIL single_rsp: got v=%b C=%0d err=%b crc=%b expected 0001 8 0 011", rsp_valid, rsp_C, rsp_err, rsp_crc);
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_C !== 32'd8 || busy !== 1'b0) begin
            errors++; $display("FAIL single_after: got v=%b C=%0d busy=%b expected 0000 8 0", rsp_valid, rsp_C, busy);
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'd100 + 32'(i), 32'(i), OP_OR);
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % N;
            checks++;
            if (req_ready !== (4'b0001 << e)) begin errors++; $display("FAIL rr_ready_%0d: got %b expected %b", g, req_ready, 4'b0001 << e); end
            step();
            checks++;
            if (core_start !== 1'b1 || core_A !== 32'd100 + 32'(e) || grant_id !== 2'(e)) begin
                errors++; $display("FAIL rr_issue_%0d: got start=%b A=%0d grant=%0d expected 1 %0d %0d", g, core_start, core_A, grant_id, 100 + e, e);
            end
            step();
            core_done = 1'b1; core_C = 32'hC0 + 32'(e); core_flags = 4'd0; core_crc = 3'd0;
            step();
            core_done = 1'b0;
            #1;
            checks++;
            if (rsp_valid !== (4'b0001 << e) || rsp_C !== 32'hC0 + 32'(e)) begin
                errors++; $display("FAIL rr_rsp_%0d: got v=%b C=%h expected %b %h", g, rsp_valid, rsp_C, 4'b0001 << e, 32'hC0 + e);
            end
            if (g == 4) req_valid = 4'b0000;
            step();
        end
    endtask

    task automatic test_timeout();
        set_req(1, 32'd7, 32'd7, OP_SUB);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_ready: got %b expected 0010", req_ready); end
        step();
        req_valid = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
                errors++; $display("FAIL to_wait_%0d: got v=%b busy=%b expected 0000 1", i, rsp_valid, busy);
            end
        end
        step();
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_C !== 32'd0 || rsp_flags !== 4'd0 || rsp_crc !== 3'd0) begin
            errors++; $display("FAIL to_rsp: got v=%b err=%b C=%h fl=%b crc=%b expected 0010 1 0 0 0", rsp_valid, rsp_err, rsp_C, rsp_flags, rsp_crc);
        end
        step();
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_next_ready: got %b expected 0010", req_ready); end
        step();
        req_valid = 4'b0000;
        step();
        core_done = 1'b1; core_C = 32'h1234;
        step();
        core_done = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_C !== 32'h1234) begin
            errors++; $display("FAIL to_next_rsp: got v=%b err=%b C=%h expected 0010 0 1234", rsp_valid, rsp_err, rsp_C);
        end
        step();
    endtask

    task automatic test_collision();
        set_req(2, 32'd1, 32'd2, OP_AND);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL col_ready: got %b expected 0100", req_ready); end
        step();
        req_valid = 4'b0000;
        for (int i = 1; i <= 7; i++) step();
        step();
        core_done = 1'b1; core_C = 32'hDEADBEEF; core_flags = 4'b1010; core_crc = 3'b101;
        step();
        core_done = 1'b0; core_flags = 4'd0; core_crc = 3'd0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_err !== 1'b0 || rsp_C !== 32'hDEADBEEF || rsp_flags !== 4'b1010 || rsp_crc !== 3'b101) begin
            errors++; $display("FAIL col_rsp: got v=%b err=%b C=%h fl=%b crc=%b expected 0100 0 deadbeef 1010 101", rsp_valid, rsp_err, rsp_C, rsp_flags, rsp_crc);
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        set_req(3, 32'd9, 32'd9, OP_ADD);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL rmw_ready: got %b expected 1000", req_ready); end
        step();
        req_valid = 4'b0000;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_C !== 32'd0) begin errors++; $display("FAIL rmw_cleared: got busy=%b C=%h expected 0 0", busy, rsp_C); end
        step();
        core_done = 1'b1; core_C = 32'd99;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmw_late_done: got %b expected 0000", rsp_valid); end
        step();
        core_done = 1'b0;
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_C !== 32'd0) begin
            errors++; $display("FAIL rmw_ignored: got v=%b busy=%b C=%h expected 0000 0 0", rsp_valid, busy, rsp_C);
        end
        for (int i = 0; i < N; i++) set_req(i, 32'd10 + 32'(i), 32'd0, OP_ADD);
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmw_next_grant: got %b expected 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        step();
        core_done = 1'b1; core_C = 32'h55;
        step();
        core_done = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_C !== 32'h55) begin
            errors++; $display("FAIL rmw_next_rsp: got v=%b C=%h expected 0001 55", rsp_valid, rsp_C);
        end
        step();
    endtask

    task automatic test_spurious_done();
        req_valid = 4'b0000;
        core_done = 1'b1; core_C = 32'hFFFFFFFF; core_flags = 4'hF; core_crc = 3'h7;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || core_start !== 1'b0) begin
            errors++; $display("FAIL spur_comb: got v=%b start=%b expected 0000 0", rsp_valid, core_start);
        end
        step();
        step();
        core_done = 1'b0;
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || core_start !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL spur_ctrl: got v=%b busy=%b start=%b ready=%b expected all 0", rsp_valid, busy, core_start, req_ready);
        end
        checks++;
        if (rsp_C !== 32'h55 || rsp_flags !== 4'd0 || rsp_crc !== 3'd0 || rsp_err !== 1'b0 || grant_id !== 2'd0) begin
            errors++; $display("FAIL spur_data: got C=%h fl=%b crc=%b err=%b grant=%0d expected 55 0 0 0 0", rsp_C, rsp_flags, rsp_crc, rsp_err, grant_id);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_A = '0; req_B = '0; req_OP = '0;
        core_done = 1'b0; core_C = '0; core_flags = '0; core_crc = '0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_timeout();
        test_collision();
        test_reset_mid_wait();
        test_spurious_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
